// File: rtl/register_bank_ctx.sv
// Multi-context register file with a nested interrupt context stack.
// Interrupt entry copies the active bank into the next one; exit just pops back.
module register_bank_ctx #(
  parameter int REG_NUM    = 32,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_CTX    = 4,
  parameter int ZERO_REG   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       irq_enter,
  input  logic                       irq_exit,
  input  logic                       write_en,
  input  logic [$clog2(REG_NUM)-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic [$clog2(REG_NUM)-1:0] read_addr_a,
  input  logic [$clog2(REG_NUM)-1:0] read_addr_b,
  input  logic                       err_clr,
  output logic [DATA_WIDTH-1:0]      data_out_a,
  output logic [DATA_WIDTH-1:0]      data_out_b,
  output logic                       busy,
  output logic [$clog2(NUM_CTX)-1:0] ctx_level,
  output logic                       ctx_err
);

  localparam int AW = $clog2(REG_NUM);
  localparam int CW = $clog2(NUM_CTX);
  localparam logic [CW-1:0] TOP_LVL   = CW'(NUM_CTX - 1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(REG_NUM - 1);
  localparam logic [AW-1:0] FIRST_IDX = (ZERO_REG != 0) ? AW'(1) : AW'(0);

  typedef enum logic {IDLE, COPY} state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         copyIdx_q, copyIdx_d;
  logic [CW-1:0]         ctxLevel_q, ctxLevel_d;
  logic                  ctxErr_q, ctxErr_d;
  logic [CW-1:0]         nextLvl;
  logic                  wrAllowed;
  logic                  dropReq;
  logic [DATA_WIDTH-1:0] regs_q [NUM_CTX][REG_NUM];

  assign nextLvl = ctxLevel_q + CW'(1);

  always_comb begin
    state_d    = state_q;
    copyIdx_d  = copyIdx_q;
    ctxLevel_d = ctxLevel_q;
    dropReq    = 1'b0;
    wrAllowed  = 1'b0;
    case (state_q)
      IDLE: begin
        wrAllowed = write_en && !((ZERO_REG != 0) && (write_addr == '0));
        // Simultaneous enter+exit is treated as a no-op, not as an error.
        if (irq_enter && !irq_exit) begin
          if (ctxLevel_q != TOP_LVL) begin
            state_d   = COPY;
            copyIdx_d = FIRST_IDX;
          end else begin
            dropReq = 1'b1;
          end
        end else if (irq_exit && !irq_enter) begin
          if (ctxLevel_q != '0) ctxLevel_d = ctxLevel_q - CW'(1);
          else                  dropReq    = 1'b1;
        end
      end
      COPY: begin
        dropReq   = irq_enter | irq_exit;
        copyIdx_d = copyIdx_q + AW'(1);
        if (copyIdx_q == LAST_IDX) begin
          state_d    = IDLE;
          ctxLevel_d = nextLvl;
          copyIdx_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    ctxErr_d = dropReq ? 1'b1 : (err_clr ? 1'b0 : ctxErr_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      copyIdx_q  <= '0;
      ctxLevel_q <= '0;
      ctxErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      copyIdx_q  <= copyIdx_d;
      ctxLevel_q <= ctxLevel_d;
      ctxErr_q   <= ctxErr_d;
    end
  end

  // CPU writes only happen in IDLE, so they never collide with a copy beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CTX; c++)
        for (int r = 0; r < REG_NUM; r++)
          regs_q[c][r] <= '0;
    end else if (wrAllowed) begin
      regs_q[ctxLevel_q][write_addr] <= data_in;
    end else if (state_q == COPY) begin
      regs_q[nextLvl][copyIdx_q] <= regs_q[ctxLevel_q][copyIdx_q];
    end
  end

  always_comb begin
    data_out_a = regs_q[ctxLevel_q][read_addr_a];
    data_out_b = regs_q[ctxLevel_q][read_addr_b];
    if ((ZERO_REG != 0) && (read_addr_a == '0)) data_out_a = '0;
    if ((ZERO_REG != 0) && (read_addr_b == '0)) data_out_b = '0;
  end

  assign busy      = (state_q == COPY);
  assign ctx_level = ctxLevel_q;
  assign ctx_err   = ctxErr_q;

endmodule

// File: doc/register_bank_ctx.md
# register_bank_ctx

Multi-context CPU register file with a nested interrupt context stack. It generalises the single main/shadow pair to NUM_CTX banks. On interrupt entry it copies the active context into the next context in hardware, so the handler starts with a consistent register image. On interrupt exit it returns to the previous context and discards the handler's context. It sits in decode/writeback in place of the CPU register bank, and the pipeline stalls on `busy`.

## Interface
Parameters:
- REG_NUM, 32, registers per context (≥2).
- DATA_WIDTH, 64, register width.
- NUM_CTX, 4, number of contexts (≥2); maximum nesting depth is NUM_CTX-1.
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes; it is also skipped by the copy.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- irq_enter  in  1  single-cycle interrupt-entry request.
- irq_exit  in  1  single-cycle interrupt-return request.
- write_en  in  1  CPU write enable.
- write_addr  in  $clog2(REG_NUM)  CPU write address.
- data_in  in  DATA_WIDTH  CPU write data.
- read_addr_a  in  $clog2(REG_NUM)  read port A address.
- read_addr_b  in  $clog2(REG_NUM)  read port B address.
- err_clr  in  1  clears `ctx_err`.
- data_out_a  out  DATA_WIDTH  port A data from the active context (combinational).
- data_out_b  out  DATA_WIDTH  port B data from the active context (combinational).
- busy  out  1  context copy in progress; the pipeline must stall.
- ctx_level  out  $clog2(NUM_CTX)  active context index (0 = base).
- ctx_err  out  1  sticky flag: an entry or exit request was dropped.

## Operation
- Storage: NUM_CTX × REG_NUM × DATA_WIDTH flip-flops. Only the context selected by `ctx_level` is readable or writable by the CPU.
- FSM states:
  - IDLE: normal register-file operation.
  - COPY: sequential copy of context L into context L+1.
- Reset (async, reset low):
  - every register in every context = 0;
  - ctx_level = 0, state = IDLE, busy = 0, ctx_err = 0, copy index = 0.
  - Reset asserted mid-COPY aborts the copy; the same reset values apply.
- IDLE + write_en:
  - register[ctx_level][write_addr] ← data_in;
  - ignored when ZERO_REG=1 and write_addr = 0.
- IDLE + irq_enter alone, ctx_level < NUM_CTX-1:
  - enter COPY with copy index = (ZERO_REG ? 1 : 0);
  - a write_en in the same cycle is performed first, and the copy picks up the written value.
- COPY, each cycle:
  - register[L+1][idx] ← register[L][idx], then idx increments;
  - after idx = REG_NUM-1 is copied: ctx_level ← L+1 and state ← IDLE.
- COPY restrictions:
  - write_en is ignored, since the pipeline is stalled;
  - reads return context L;
  - irq_enter or irq_exit arriving during COPY is dropped and sets ctx_err.
- IDLE + irq_exit alone, ctx_level > 0: ctx_level ← ctx_level-1 on the next edge, with no copy. A write_en in the same cycle still lands in the exiting context.
- Dropped requests (each sets ctx_err):
  - irq_enter at ctx_level = NUM_CTX-1;
  - irq_exit at ctx_level = 0.
- irq_enter and irq_exit together in IDLE: both ignored, ctx_err unchanged.
- ctx_err:
  - set by any dropped request;
  - cleared by err_clr;
  - if set and clear occur in the same cycle, set wins.
- ZERO_REG=1: data_out_a/b = 0 whenever the read address is 0.

## Timing
- Reads are combinational with no write bypass: a same-cycle write is visible from the next cycle.
- Entry latency:
  - busy rises the cycle after irq_enter is sampled;
  - busy stays high for C = REG_NUM - ZERO_REG cycles;
  - ctx_level updates on the same edge at which busy falls.
  - Defaults: C = 31, so ctx_level changes 31 edges after the edge that samples irq_enter.
- Exit latency: ctx_level updates on the edge that samples irq_exit; busy stays 0.
- ctx_level and busy are registered outputs.

## Test plan
- Reset: write 0xA5 to reg 5, then assert reset mid-cycle (asynchronously) → outputs clear immediately; reg 5 reads 0, ctx_level = 0, busy = 0.
- Entry copy:
  - write reg 3 = 0x1234 in context 0, then pulse irq_enter;
  - busy is high for exactly 31 cycles, then ctx_level = 1;
  - reg 3 reads 0x1234;
  - write reg 3 = 0xBEEF, pulse irq_exit → ctx_level = 0 and reg 3 reads 0x1234.
- Nesting limit: with NUM_CTX = 4, do three complete entries → ctx_level = 3; a fourth irq_enter is dropped, ctx_err = 1, and ctx_level stays 3.
- Underflow, clear and ZERO_REG:
  - irq_exit at level 0 → ctx_err = 1; err_clr → ctx_err = 0;
  - write reg 0 = 0xFF → reg 0 still reads 0.
- During COPY:
  - irq_exit and write reg 7 = 0x99 issued mid-copy → both dropped, ctx_err = 1;
  - after the copy, reg 7 holds its pre-copy value in both contexts.
- Simultaneous requests: irq_enter and irq_exit together at level 1 → no change and ctx_err stays 0. A write in the same cycle as irq_enter appears in the new context.
